// File: rtl/camera_yuv_rgb_scan.sv
// camera_yuv_rgb_scan: YUV422 camera byte stream to packed RGB pixels.
//   pclk, rst_n            : pixel clock, async active-low reset
//   href, vsync, cam_data  : camera line qualifier, frame sync, byte
//   pix_data, pix_valid    : packed RGB332/565/888 pixel and its strobe
//   pix_x, pix_y, pix_sof  : pixel coordinates, first-pixel-of-frame flag
//   line_done, line_len    : end-of-line pulse and pixels on that line
//   fmt_err                : partial pair at line end, or X/Y overflow
module camera_yuv_rgb_scan #(
    parameter  int OUT_FMT    = 0,
    parameter  int BYTE_ORDER = 0,
    parameter  int MAX_W      = 640,
    parameter  int MAX_H      = 480,
    localparam int OUT_W      = (OUT_FMT == 0) ? 8 :
                                (OUT_FMT == 1) ? 16 : 24,
    localparam int X_W        = $clog2(MAX_W),
    localparam int Y_W        = $clog2(MAX_H)
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             href,
    input  logic             vsync,
    input  logic [7:0]       cam_data,
    output logic [OUT_W-1:0] pix_data,
    output logic             pix_valid,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    output logic             pix_sof,
    output logic             line_done,
    output logic [X_W-1:0]   line_len,
    output logic             fmt_err
);

    // Counters carry one spare bit so they can sit at MAX_W / MAX_H.
    localparam logic [X_W:0] X_LIM = (X_W+1)'(MAX_W);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(MAX_H);

    // Capture slots: 0=Y0 1=U 2=Y1 3=V
    function automatic logic [1:0] slot_of(input logic [1:0] ph);
        logic [1:0] s;
        case (BYTE_ORDER)
            1:       s = {ph[1], ~ph[0]};
            2: begin
                case (ph)
                    2'd0:    s = 2'd0;
                    2'd1:    s = 2'd3;
                    2'd2:    s = 2'd2;
                    default: s = 2'd1;
                endcase
            end
            3: begin
                case (ph)
                    2'd0:    s = 2'd3;
                    2'd1:    s = 2'd0;
                    2'd2:    s = 2'd1;
                    default: s = 2'd2;
                endcase
            end
            default: s = ph;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] sat(input logic signed [11:0] v);
        if (v < 12'sd0)
            return 8'd0;
        else if (v > 12'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    function automatic logic [OUT_W-1:0] pack(input logic [7:0] r,
                                              input logic [7:0] g,
                                              input logic [7:0] b);
        logic [23:0] w;
        case (OUT_FMT)
            0:       w = {16'd0, r[7:5], g[7:5], b[7:6]};
            1:       w = {8'd0, r[7:3], g[7:2], b[7:3]};
            default: w = {r, g, b};
        endcase
        return w[OUT_W-1:0];
    endfunction

    logic [1:0]       phase;
    logic             last_href;
    logic [X_W:0]     x_cnt;
    logic [Y_W:0]     y_cnt;
    logic             sof_pend;
    logic             err_line;
    logic [7:0]       cap [4];

    // Completed pair, coordinates reserved at capture time
    logic             pr_vld, pr_ok0, pr_ok1, pr_err0, pr_err1;
    logic [X_W-1:0]   pr_x;
    logic [Y_W-1:0]   pr_y;

    // Converted pair awaiting emission
    logic             st_vld, st_ok0, st_ok1, st_err0, st_err1;
    logic [X_W-1:0]   st_x;
    logic [Y_W-1:0]   st_y;
    logic [OUT_W-1:0] st_pk0, st_pk1;
    logic             p1_vld;

    logic signed [11:0] yp0, yp1, up, vp, r_off, g_off, b_off;
    logic [OUT_W-1:0]   pk0, pk1;
    logic               fall, ok0, ok1, emit;

    always_comb begin
        yp0   = $signed({4'd0, cap[0]}) - 12'sd16;
        yp1   = $signed({4'd0, cap[2]}) - 12'sd16;
        up    = $signed({4'd0, cap[1]}) - 12'sd128;
        vp    = $signed({4'd0, cap[3]}) - 12'sd128;
        r_off = vp + (vp >>> 2);
        g_off = (up >>> 2) + (vp >>> 1);
        b_off = up + (up >>> 1) + (up >>> 2);
        pk0   = pack(sat(yp0 + r_off), sat(yp0 - g_off), sat(yp0 + b_off));
        pk1   = pack(sat(yp1 + r_off), sat(yp1 - g_off), sat(yp1 + b_off));
    end

    // A pair's second pixel is in range only if its first one is too.
    assign fall = last_href & ~href;
    assign ok0  = (x_cnt < X_LIM) && (y_cnt < Y_LIM);
    assign ok1  = ((x_cnt + (X_W+1)'(1)) < X_LIM) && (y_cnt < Y_LIM);
    assign emit = st_vld ? st_ok0 : st_ok1;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            last_href <= 1'b0;
            x_cnt     <= '0;
            y_cnt     <= '0;
            sof_pend  <= 1'b1;
            err_line  <= 1'b0;
            for (int i = 0; i < 4; i++) cap[i] <= '0;
            pr_vld    <= 1'b0;
            pr_ok0    <= 1'b0;
            pr_ok1    <= 1'b0;
            pr_err0   <= 1'b0;
            pr_err1   <= 1'b0;
            pr_x      <= '0;
            pr_y      <= '0;
            st_vld    <= 1'b0;
            st_ok0    <= 1'b0;
            st_ok1    <= 1'b0;
            st_err0   <= 1'b0;
            st_err1   <= 1'b0;
            st_x      <= '0;
            st_y      <= '0;
            st_pk0    <= '0;
            st_pk1    <= '0;
            p1_vld    <= 1'b0;
            pix_data  <= '0;
            pix_valid <= 1'b0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_sof   <= 1'b0;
            line_done <= 1'b0;
            line_len  <= '0;
            fmt_err   <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            line_done <= 1'b0;
            fmt_err   <= 1'b0;
            pr_vld    <= 1'b0;
            st_vld    <= 1'b0;
            p1_vld    <= 1'b0;
            if (vsync) begin
                // Frame restart: pending pixels are dropped.
                phase     <= '0;
                last_href <= 1'b0;
                x_cnt     <= '0;
                y_cnt     <= '0;
                sof_pend  <= 1'b1;
                err_line  <= 1'b0;
            end else begin
                last_href <= href;
                st_vld    <= pr_vld;
                if (pr_vld) begin
                    st_pk0  <= pk0;
                    st_pk1  <= pk1;
                    st_ok0  <= pr_ok0;
                    st_ok1  <= pr_ok1;
                    st_err0 <= pr_err0;
                    st_err1 <= pr_err1;
                    st_x    <= pr_x;
                    st_y    <= pr_y;
                end
                p1_vld <= st_vld;
                if (st_vld || p1_vld) begin
                    pix_valid <= emit;
                    fmt_err   <= st_vld ? st_err0 : st_err1;
                    if (emit) begin
                        pix_data <= st_vld ? st_pk0 : st_pk1;
                        pix_x    <= st_vld ? st_x : st_x + X_W'(1);
                        pix_y    <= st_y;
                        pix_sof  <= sof_pend;
                        sof_pend <= 1'b0;
                    end
                end
                if (fall) begin
                    line_done <= 1'b1;
                    line_len  <= x_cnt[X_W-1:0];
                    x_cnt     <= '0;
                    err_line  <= 1'b0;
                    phase     <= '0;
                    if (y_cnt < Y_LIM)
                        y_cnt <= y_cnt + (Y_W+1)'(1);
                    if (phase != 2'd0)
                        fmt_err <= 1'b1;
                end else if (href) begin
                    cap[slot_of(phase)] <= cam_data;
                    phase <= phase + 2'd1;
                    if (phase == 2'd3) begin
                        pr_vld  <= 1'b1;
                        pr_ok0  <= ok0;
                        pr_ok1  <= ok1;
                        pr_err0 <= ~ok0 & ~err_line;
                        pr_err1 <= ok0 & ~ok1 & ~err_line;
                        pr_x    <= x_cnt[X_W-1:0];
                        pr_y    <= y_cnt[Y_W-1:0];
                        if (!ok1)
                            err_line <= 1'b1;
                        if (ok1)
                            x_cnt <= x_cnt + (X_W+1)'(2);
                        else if (ok0)
                            x_cnt <= x_cnt + (X_W+1)'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_camera_yuv_rgb_scan.sv
// tb_camera_yuv_rgb_scan: four parameter sets driven by one camera
// stream, checked against an event-level reference model.
module tb_camera_yuv_rgb_scan;

    logic       pclk;
    logic       rst_n;
    logic       href;
    logic       vsync;
    logic [7:0] cam_data;

    logic [7:0]  pd0;
    logic [15:0] pd1;
    logic [23:0] pd2;
    logic [7:0]  pd3;
    logic [9:0]  x0, x1, x3, l0, l1, l3;
    logic [2:0]  x2, l2;
    logic [8:0]  y0, y1, y3;
    logic [1:0]  y2;
    logic [3:0]  v, sof, ld, er;

    camera_yuv_rgb_scan #(.OUT_FMT(0), .BYTE_ORDER(0),
                          .MAX_W(640), .MAX_H(480)) u0 (
        .pclk(pclk), .rst_n(rst_n), .href(href), .vsync(vsync),
        .cam_data(cam_data), .pix_data(pd0), .pix_valid(v[0]),
        .pix_x(x0), .pix_y(y0), .pix_sof(sof[0]), .line_done(ld[0]),
        .line_len(l0), .fmt_err(er[0]));

    camera_yuv_rgb_scan #(.OUT_FMT(1), .BYTE_ORDER(2),
                          .MAX_W(640), .MAX_H(480)) u1 (
        .pclk(pclk), .rst_n(rst_n), .href(href), .vsync(vsync),
        .cam_data(cam_data), .pix_data(pd1), .pix_valid(v[1]),
        .pix_x(x1), .pix_y(y1), .pix_sof(sof[1]), .line_done(ld[1]),
        .line_len(l1), .fmt_err(er[1]));

    camera_yuv_rgb_scan #(.OUT_FMT(2), .BYTE_ORDER(1),
                          .MAX_W(5), .MAX_H(3)) u2 (
        .pclk(pclk), .rst_n(rst_n), .href(href), .vsync(vsync),
        .cam_data(cam_data), .pix_data(pd2), .pix_valid(v[2]),
        .pix_x(x2), .pix_y(y2), .pix_sof(sof[2]), .line_done(ld[2]),
        .line_len(l2), .fmt_err(er[2]));

    camera_yuv_rgb_scan #(.OUT_FMT(0), .BYTE_ORDER(3),
                          .MAX_W(640), .MAX_H(480)) u3 (
        .pclk(pclk), .rst_n(rst_n), .href(href), .vsync(vsync),
        .cam_data(cam_data), .pix_data(pd3), .pix_valid(v[3]),
        .pix_x(x3), .pix_y(y3), .pix_sof(sof[3]), .line_done(ld[3]),
        .line_len(l3), .fmt_err(er[3]));

    logic [23:0] o_data [4];
    logic [15:0] o_x [4];
    logic [15:0] o_y [4];
    logic [15:0] o_len [4];

    assign o_data[0] = 24'(pd0);
    assign o_data[1] = 24'(pd1);
    assign o_data[2] = pd2;
    assign o_data[3] = 24'(pd3);
    assign o_x[0] = 16'(x0);
    assign o_x[1] = 16'(x1);
    assign o_x[2] = 16'(x2);
    assign o_x[3] = 16'(x3);
    assign o_y[0] = 16'(y0);
    assign o_y[1] = 16'(y1);
    assign o_y[2] = 16'(y2);
    assign o_y[3] = 16'(y3);
    assign o_len[0] = 16'(l0);
    assign o_len[1] = 16'(l1);
    assign o_len[2] = 16'(l2);
    assign o_len[3] = 16'(l3);

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int fmt [4] = '{0, 1, 2, 0};
    int bo  [4] = '{0, 2, 1, 3};
    int mw  [4] = '{640, 640, 5, 640};
    int mh  [4] = '{480, 480, 3, 480};

    typedef struct {
        int          due;
        bit          pix;
        logic [23:0] data;
        int          x;
        int          y;
    } ev_t;

    ev_t evq [4][$];
    int  mx [4];
    int  my [4];
    bit  sofp [4];
    bit  errl [4];
    int  pb [4];
    int  ph;
    bit  lasth;
    int  cyc_n;

    bit          e_v [4];
    bit          e_sof [4];
    bit          e_ld [4];
    bit          e_err [4];
    logic [23:0] e_data [4];
    int          e_x [4];
    int          e_y [4];
    int          e_len [4];

    int total;
    int bad;

    function automatic int clip(int a);
        if (a < 0) return 0;
        if (a > 255) return 255;
        return a;
    endfunction

    function automatic logic [23:0] px(int f, int yy, int uu, int vv);
        int yq, uq, vq, r, g, b;
        yq = yy - 16;
        uq = uu - 128;
        vq = vv - 128;
        r = clip(yq + vq + (vq >>> 2));
        g = clip(yq - (uq >>> 2) - (vq >>> 1));
        b = clip(yq + uq + (uq >>> 1) + (uq >>> 2));
        if (f == 0) return 24'((r / 32) * 32 + (g / 32) * 4 + b / 64);
        if (f == 1) return 24'((r / 8) * 2048 + (g / 4) * 32 + b / 8);
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            evq[i].delete();
            mx[i] = 0;
            my[i] = 0;
            sofp[i] = 1'b1;
            errl[i] = 1'b0;
        end
        ph = 0;
        lasth = 1'b0;
    endtask

    // Expected outputs right after the current rising edge.
    task automatic model_edge();
        bit  fall;
        ev_t e;
        int  ya, ua, yb, va;
        fall = lasth && !href;
        if (!vsync && href) pb[ph] = int'(cam_data);
        for (int i = 0; i < 4; i++) begin
            e_v[i] = 1'b0;
            e_sof[i] = 1'b0;
            e_ld[i] = 1'b0;
            e_err[i] = 1'b0;
            if (vsync) begin
                evq[i].delete();
                mx[i] = 0;
                my[i] = 0;
                sofp[i] = 1'b1;
                errl[i] = 1'b0;
            end else begin
                while (evq[i].size() > 0 && evq[i][0].due == cyc_n) begin
                    e = evq[i].pop_front();
                    if (e.pix) begin
                        e_v[i] = 1'b1;
                        e_data[i] = e.data;
                        e_x[i] = e.x;
                        e_y[i] = e.y;
                        e_sof[i] = sofp[i];
                        sofp[i] = 1'b0;
                    end else begin
                        e_err[i] = 1'b1;
                    end
                end
                if (fall) begin
                    e_ld[i] = 1'b1;
                    e_len[i] = mx[i];
                    mx[i] = 0;
                    if (my[i] < mh[i]) my[i]++;
                    errl[i] = 1'b0;
                    if (ph != 0) e_err[i] = 1'b1;
                end else if (href && ph == 3) begin
                    case (bo[i])
                        0: begin ya = pb[0]; ua = pb[1]; yb = pb[2]; va = pb[3]; end
                        1: begin ua = pb[0]; ya = pb[1]; va = pb[2]; yb = pb[3]; end
                        2: begin ya = pb[0]; va = pb[1]; yb = pb[2]; ua = pb[3]; end
                        default: begin va = pb[0]; ya = pb[1]; ua = pb[2]; yb = pb[3]; end
                    endcase
                    for (int k = 0; k < 2; k++) begin
                        e.due = cyc_n + 2 + k;
                        e.x = mx[i];
                        e.y = my[i];
                        if (mx[i] < mw[i] && my[i] < mh[i]) begin
                            e.pix = 1'b1;
                            e.data = px(fmt[i], (k == 0) ? ya : yb, ua, va);
                            evq[i].push_back(e);
                            mx[i]++;
                        end else if (!errl[i]) begin
                            e.pix = 1'b0;
                            e.data = '0;
                            evq[i].push_back(e);
                            errl[i] = 1'b1;
                        end
                    end
                end
            end
        end
        if (vsync || fall) ph = 0;
        else if (href) ph = (ph + 1) % 4;
        lasth = href && !vsync;
    endtask

    task automatic chk(input string tag, input int i,
                       input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s u%0d cyc=%0d got=%0h exp=%0h",
                   tag, i, cyc_n, got, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk("pix_valid", i, 32'(v[i]), 32'(e_v[i]));
            chk("pix_sof", i, 32'(sof[i]), 32'(e_sof[i]));
            chk("line_done", i, 32'(ld[i]), 32'(e_ld[i]));
            chk("fmt_err", i, 32'(er[i]), 32'(e_err[i]));
            if (e_v[i]) begin
                chk("pix_data", i, 32'(o_data[i]), 32'(e_data[i]));
                chk("pix_x", i, 32'(o_x[i]), 32'(e_x[i]));
                chk("pix_y", i, 32'(o_y[i]), 32'(e_y[i]));
            end
            if (e_ld[i])
                chk("line_len", i, 32'(o_len[i]), 32'(e_len[i]));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_valid"}, i, 32'(v[i]), 32'd0);
            chk({tag, "_sof"}, i, 32'(sof[i]), 32'd0);
            chk({tag, "_ld"}, i, 32'(ld[i]), 32'd0);
            chk({tag, "_err"}, i, 32'(er[i]), 32'd0);
            chk({tag, "_data"}, i, 32'(o_data[i]), 32'd0);
            chk({tag, "_x"}, i, 32'(o_x[i]), 32'd0);
            chk({tag, "_y"}, i, 32'(o_y[i]), 32'd0);
            chk({tag, "_len"}, i, 32'(o_len[i]), 32'd0);
        end
    endtask

    task automatic step(input bit h, input bit vs, input int d);
        href = h;
        vsync = vs;
        cam_data = d[7:0];
        @(posedge pclk);
        cyc_n++;
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 0);
    endtask

    task automatic send_pair(input int a, input int b,
                             input int c, input int d);
        step(1'b1, 1'b0, a);
        step(1'b1, 1'b0, b);
        step(1'b1, 1'b0, c);
        step(1'b1, 1'b0, d);
    endtask

    task automatic rnd_pair();
        send_pair($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), $urandom_range(0, 255));
    endtask

    task automatic rnd_lines(input int n);
        int np, nb;
        for (int l = 0; l < n; l++) begin
            np = $urandom_range(0, 7);
            nb = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) rnd_pair();
            for (int b = 0; b < nb; b++)
                step(1'b1, 1'b0, $urandom_range(0, 255));
            idle($urandom_range(1, 4));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        cyc_n = 0;
        rst_n = 1'b0;
        href = 1'b0;
        vsync = 1'b0;
        cam_data = 8'd0;
        model_reset();
        #12;
        check_zero("reset");
        @(negedge pclk);
        rst_n = 1'b1;
        idle(2);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 0);
        idle(2);

        // Directed line: grey/black, strong red, saturation, mid grey
        send_pair(235, 128, 16, 128);
        send_pair(81, 90, 81, 240);
        send_pair(255, 128, 255, 255);
        send_pair(128, 126, 128, 126);
        idle(4);

        // One and a half pairs, then href falls
        send_pair(40, 200, 180, 60);
        step(1'b1, 1'b0, 99);
        step(1'b1, 1'b0, 77);
        idle(4);

        rnd_lines(5);

        // vsync right after a completed pair drops that pair
        send_pair(200, 30, 100, 220);
        step(1'b0, 1'b1, 0);
        idle(3);
        send_pair(126, 128, 126, 128);
        rnd_pair();
        idle(3);
        rnd_lines(4);

        // Async reset while a pixel is on the outputs
        send_pair(235, 128, 235, 128);
        step(1'b1, 1'b0, 11);
        step(1'b1, 1'b0, 22);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        href = 1'b0;
        vsync = 1'b0;
        @(posedge pclk);
        @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;
        idle(2);
        rnd_lines(8);
        step(1'b0, 1'b1, 0);
        idle(2);
        rnd_lines(6);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/camera_yuv_rgb_scan.md
Name: camera_yuv_rgb_scan

Overview:
Parametrised camera front end. Deserialises a YUV422 byte stream (pclk/href/vsync/8-bit data) into per-pixel RGB words in a selectable output format. Emits one valid strobe per pixel, with X/Y coordinates and frame/line markers, for the downstream frame-buffer write path. Sits directly behind the camera pins, in the pclk domain.

Parameters:
OUT_FMT, 0, output packing: 0=RGB332, 1=RGB565, 2=RGB888; pix_data width OUT_W derives from it as 8/16/24
BYTE_ORDER, 0, byte order of each 4-byte pair: 0=Y0 U Y1 V, 1=U Y0 V Y1, 2=Y0 V Y1 U, 3=V Y0 U Y1
MAX_W, 640, maximum pixels per line; X_W = clog2(MAX_W)
MAX_H, 480, maximum lines per frame; Y_W = clog2(MAX_H)

Ports:
pclk  in  1  camera pixel clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
href  in  1  line-active qualifier; one byte per pclk while high
vsync  in  1  frame sync, active high
cam_data  in  8  camera byte
pix_data  out  OUT_W  packed RGB pixel
pix_valid  out  1  one-cycle strobe, pix_data/pix_x/pix_y valid
pix_x  out  X_W  column of current pixel
pix_y  out  Y_W  line of current pixel
pix_sof  out  1  high with pix_valid for pixel (0,0) of a frame
line_done  out  1  one-cycle pulse on href falling edge
line_len  out  X_W  pixels emitted on the line just ended; valid with line_done
fmt_err  out  1  one-cycle pulse: partial pair at href fall, or X/Y overflow

Behaviour:
- Reset (rst_n low, async): all outputs 0; byte phase 0; x=0, y=0; pipeline empty; sof_pending=1.
- Byte phase counter 0..3 advances on each pclk with href=1. It wraps 3->0. BYTE_ORDER maps each phase to a Y0/U/Y1/V capture register.
- Arithmetic, 12-bit signed: Y'=Y-16, U'=U-128, V'=V-128; >>> is arithmetic shift.
  - R = Y' + V' + (V'>>>2)
  - G = Y' - (U'>>>2) - (V'>>>1)
  - B = Y' + U' + (U'>>>1) + (U'>>>2)
  - Each result saturates to 0..255 (negative -> 0, >255 -> 255). Both pixels of a pair share U and V.
- Packing takes MSBs: RGB332 {R[7:5],G[7:5],B[7:6]}; RGB565 {R[7:3],G[7:2],B[7:3]}; RGB888 {R,G,B}.
- Pipeline: the phase-3 byte is sampled at edge E. Stage 1 (E+1) registers R/G/B sums for both pixels. Pixel 0 is output at edge E+2, pixel 1 at E+3, each with pix_valid high for exactly one cycle. The next pair cannot complete before E+4, so there is no overlap and no backpressure.
- Coordinates: pix_x equals the emitted-pixel count on the line before increment. After each emit, x increments.
- href falling edge (last_href=1, href=0):
  - line_done pulses; line_len = x. Pixels still in the pipeline are counted in x before line_len is taken.
  - x=0; y increments.
  - Phase resets to 0. If phase was not 0, the partial pair is discarded and fmt_err pulses.
- Overflow: a pixel with x>=MAX_W or y>=MAX_H is suppressed (no pix_valid) and pulses fmt_err once per line.
- vsync high (any cycle) is a frame reset:
  - phase=0, x=0, y=0; pipeline flushed so pending pixels are dropped; sof_pending=1.
  - href is ignored while vsync=1. vsync has priority over a simultaneous href edge.
- pix_sof is asserted with the first pix_valid after sof_pending=1, then clears sof_pending.
- rst_n asserted mid-line aborts everything immediately. The first line after release is treated as line 0.

Test Plan:
- RGB332, BYTE_ORDER 0. Send Y0=235 U=128 Y1=16 V=128 -> pix_data 0xDB at E+2, 0x00 at E+3; pix_x 0 then 1; pix_sof=1 on the first pixel only.
- RGB565. Send Y0=Y1=81, U=90, V=240 -> R=205, G=19, B=0 -> pix_data 0xC880 for both pixels. Saturation: Y=255, V=255, U=128 gives R=255.
- BYTE_ORDER 1, RGB888. Send U=128 Y0=126 V=128 Y1=126 -> both pixels 0x6E6E6E.
- href drops after 6 bytes (1.5 pairs) -> 2 pixels emitted; line_done with line_len=2; fmt_err pulse; next line starts at pix_x 0, pix_y 1.
- vsync asserted one cycle after phase-3 byte -> no pix_valid for that pair; next frame's first pixel at (0,0) with pix_sof=1.
- MAX_W=4. Send 3 pairs on one line -> 4 pix_valid, line_len=4, one fmt_err pulse. rst_n low mid-line -> all outputs 0 asynchronously.
